// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: BCD countdown timer with start/pause, runtime reload,
// saturating time bonus, low-time warning and a one-shot expiry pulse.
module bcd_countdown_timer #(
  parameter int                  DIGITS         = 2,
  parameter logic [4*DIGITS-1:0] START_VALUE    = 'h90,
  parameter logic [4*DIGITS-1:0] WARN_THRESHOLD = 'h10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  bonus_valid,
  input  logic [4*DIGITS-1:0]   bonus_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  end_game,
  output logic                  warn,
  output logic                  expired
);
  localparam int W = 4*DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] count_q, count_d, bonus_c, base;
  logic expired_q, expired_d, fire;
  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = v[4*i+:4] > 4'd9 ? 4'd9 : v[4*i+:4];
    return r;
  endfunction
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i+:4] == 4'd0) r[4*i+:4] = 4'd9;
        else begin
          r[4*i+:4] = r[4*i+:4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction
  // Per-digit add with decimal carry; a carry out of the top digit saturates.
  function automatic logic [W-1:0] bcd_sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [4:0] s, t;
    logic c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
      t = s - 5'd10;
      c = s > 5'd9;
      r[4*i+:4] = c ? t[3:0] : s[3:0];
    end
    return c ? {DIGITS{4'd9}} : r;
  endfunction
  always_comb begin
    fire = state_q == RUN && tick && !pause;
    bonus_c = clamp(bonus_value);
    base = fire && count_q != '0 ? bcd_dec(count_q) : count_q;
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      state_d = IDLE;
      count_d = clamp(load_value);
    end else if (start && state_q == IDLE) state_d = RUN;
    else if (state_q == RUN) begin
      if (fire && count_q == '0 && !(bonus_valid && bonus_c != '0)) state_d = DONE;
      else count_d = bonus_valid ? bcd_sat_add(base, bonus_c) : base;
    end
    expired_d = state_d == DONE && state_q != DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= START_VALUE;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      expired_q <= expired_d;
    end
  end
  assign count = count_q;
  assign running = state_q == RUN;
  assign end_game = state_q == DONE;
  assign warn = state_q == RUN && count_q <= WARN_THRESHOLD;
  assign expired = expired_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: drives a 2-digit and a 3-digit timer with shared
// stimulus; an integer-arithmetic model feeds a scoreboard checked every cycle.
module tb_bcd_countdown_timer;
  logic clk = 0, rst, tick, start, pause, load, bonus_valid;
  logic [11:0] load_value, bonus_value;
  logic [7:0] count0;
  logic [11:0] count1;
  logic run0, end0, warn0, exp0, run1, end1, warn1, exp1;
  logic [31:0] q[$];
  int checks = 0, errors = 0;
  int cnt[2], stt[2];
  always #5 clk = ~clk;
  bcd_countdown_timer dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load),
    .load_value(load_value[7:0]), .bonus_valid(bonus_valid), .bonus_value(bonus_value[7:0]),
    .count(count0), .running(run0), .end_game(end0), .warn(warn0), .expired(exp0)
  );
  bcd_countdown_timer #(.DIGITS(3), .START_VALUE(12'h100), .WARN_THRESHOLD(12'h010)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load),
    .load_value(load_value), .bonus_valid(bonus_valid), .bonus_value(bonus_value),
    .count(count1), .running(run1), .end_game(end1), .warn(warn1), .expired(exp1)
  );
  function automatic int bcd2int(input logic [11:0] v, input int d);
    int r, n;
    r = 0;
    for (int i = d - 1; i >= 0; i--) begin
      n = int'(v[4*i+:4]);
      r = r * 10 + (n > 9 ? 9 : n);
    end
    return r;
  endfunction
  function automatic logic [11:0] int2bcd(input int n, input int d);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
  // States: 0 idle, 1 running, 2 done; counts kept as plain integers.
  task automatic model(input int k, output logic [15:0] ex);
    int d, mx, b, base, prev;
    d = k == 0 ? 2 : 3;
    mx = k == 0 ? 99 : 999;
    prev = stt[k];
    if (rst) begin
      stt[k] = 0;
      cnt[k] = k == 0 ? 90 : 100;
    end else if (load) begin
      stt[k] = 0;
      cnt[k] = bcd2int(load_value, d);
    end else if (start && stt[k] == 0) stt[k] = 1;
    else if (stt[k] == 1) begin
      b = bcd2int(bonus_value, d);
      if (tick && !pause && cnt[k] == 0 && !(bonus_valid && b != 0)) stt[k] = 2;
      else begin
        base = (tick && !pause && cnt[k] > 0) ? cnt[k] - 1 : cnt[k];
        if (bonus_valid) base = base + b > mx ? mx : base + b;
        cnt[k] = base;
      end
    end
    if (rst) prev = 2;
    ex = {int2bcd(cnt[k], d), stt[k] == 1, stt[k] == 2, stt[k] == 1 && cnt[k] <= 10,
          stt[k] == 2 && prev != 2};
  endtask
  task automatic step(input logic r, input logic ld, input logic [11:0] lv, input logic s,
                      input logic t, input logic p, input logic bvl, input logic [11:0] bv);
    logic [15:0] e0, e1;
    rst = r; load = ld; load_value = lv; start = s; tick = t; pause = p;
    bonus_valid = bvl; bonus_value = bv;
    model(0, e0);
    model(1, e1);
    @(posedge clk);
    q.push_back({e0, e1});
    @(negedge clk);
  endtask
  task automatic load_run(input logic [11:0] v);
    step(0, 1, v, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] e;
    logic [15:0] a0, a1;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a0 = {4'h0, count0, run0, end0, warn0, exp0};
        a1 = {count1, run1, end1, warn1, exp1};
        checks += 2;
        if (a0 !== e[31:16]) begin
          errors++;
          $display("FAIL d2 {count,run,end,warn,exp} got %h expected %h", a0, e[31:16]);
        end
        if (a1 !== e[15:0]) begin
          errors++;
          $display("FAIL d3 {count,run,end,warn,exp} got %h expected %h", a1, e[15:0]);
        end
      end
    end
  end
  initial begin
    logic [11:0] lv, bv;
    {rst, tick, start, pause, load, bonus_valid} = '0;
    load_value = '0;
    bonus_value = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 1, 0, 1, 12'h005);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 85; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    load_run(12'h001);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    load_run(12'h095);
    step(0, 0, 0, 0, 0, 0, 1, 12'h007);
    load_run(12'h040);
    step(0, 0, 0, 0, 1, 0, 1, 12'h015);
    load_run(12'h000);
    step(0, 0, 0, 0, 1, 0, 1, 12'h005);
    load_run(12'h000);
    step(0, 0, 0, 0, 1, 0, 1, 12'h000);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    load_run(12'h030);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 12'h002);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    load_run(12'h999);
    step(0, 0, 0, 0, 1, 0, 1, 12'h999);
    step(0, 1, 12'hA5F, 0, 1, 0, 1, 12'h001);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      lv = $urandom_range(1) ? 12'($urandom) : 12'($urandom_range(3));
      bv = $urandom_range(2) == 0 ? 12'h000 : ($urandom_range(1) ? 12'($urandom) : 12'($urandom_range(12)));
      step($urandom_range(200) == 0, $urandom_range(40) == 0, lv, $urandom_range(7) == 0,
           $urandom_range(1) == 1, $urandom_range(3) == 0, $urandom_range(9) == 0, bv);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
